// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core.
// Handles the hazards the forwarding unit cannot hide: load-use bubbles,
// multi-cycle MULT/DIV occupancy of EX, and taken-branch / exception flushes.
// It also keeps a free-running count of cycles in which the PC was held.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   ifid_instr      instruction word held in IF/ID
//   idex_instr      instruction word held in ID/EX
//   branch_taken    branch/jump in ID resolved taken this cycle
//   exception       exception detected in MEM this cycle
//   pc_write        PC update enable
//   ifid_write      IF/ID load enable
//   idex_write      ID/EX load enable
//   ifid_flush      load NOP into IF/ID
//   idex_flush      load NOP into ID/EX (bubble)
//   exmem_flush     load NOP into EX/MEM
//   md_start        one-cycle start pulse to the mul/div unit
//   md_abort        one-cycle abort pulse to the mul/div unit
//   md_busy         high while waiting on the mul/div unit
//   stall_count     cycles with pc_write low since reset; wraps
module hazard_stall_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ifid_instr,
  input  logic [31:0] idex_instr,
  input  logic        branch_taken,
  input  logic        exception,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        idex_write,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        md_start,
  output logic        md_abort,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  typedef enum logic [0:0] {StRun, StMdWait} state_e;

  // Counter reload values: total hold equals the unit latency, the first hold
  // cycle being the one that issues md_start.
  localparam logic [5:0] MulCntInit = 6'(MUL_LAT - 1);
  localparam logic [5:0] DivCntInit = 6'(DIV_LAT - 1);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Field extraction
  logic [5:0] ifid_op, idex_op, idex_funct;
  logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt;

  assign ifid_op    = ifid_instr[31:26];
  assign ifid_rs    = ifid_instr[25:21];
  assign ifid_rt    = ifid_instr[20:16];
  assign idex_op    = idex_instr[31:26];
  assign idex_rs    = idex_instr[25:21];
  assign idex_rt    = idex_instr[20:16];
  assign idex_funct = idex_instr[5:0];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{ifid_instr[15:0], idex_instr[15:6]};

  // Decode
  logic is_load, uses_rs, uses_rt, load_use, is_md, is_div;

  always_comb begin
    // lw, lb, lbu, and mfc0 (COP0 with rs=0) all write rt late
    is_load = (idex_op == 6'b100011) || (idex_op == 6'b100000) ||
              (idex_op == 6'b100100) ||
              ((idex_op == 6'b010000) && (idex_rs == 5'b00000));

    // j, jal and COP0 ops do not read rs
    uses_rs = !((ifid_op == 6'b000010) || (ifid_op == 6'b000011) ||
                (ifid_op == 6'b010000));

    // R-type, sw, sb, beq, bne and mtc0 read rt
    uses_rt = (ifid_op == 6'b000000) || (ifid_op == 6'b101011) ||
              (ifid_op == 6'b101000) || (ifid_op == 6'b000100) ||
              (ifid_op == 6'b000101) ||
              ((ifid_op == 6'b010000) && (ifid_rs == 5'b00100));

    load_use = is_load && (idex_rt != 5'd0) &&
               ((uses_rs && (ifid_rs == idex_rt)) ||
                (uses_rt && (ifid_rt == idex_rt)));

    is_md  = (idex_op == 6'b000000) && (idex_funct[5:2] == 4'b0110);
    is_div = idex_funct[1];
  end

  // Next state and outputs
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    md_start    = 1'b0;
    md_abort    = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;

    if (reset) begin
      // Reset dominates; the mul/div unit is reset on its own, so no abort.
      state_d = StRun;
      cnt_d   = 6'd0;
    end else if (exception) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      md_abort    = (state_q == StMdWait);
      state_d     = StRun;
      cnt_d       = 6'd0;
    end else if ((state_q == StMdWait) && (cnt_q != 6'd0)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      cnt_d       = cnt_q - 6'd1;
    end else if (state_q == StMdWait) begin
      // Release cycle: mul/div leaves EX at this edge.
      state_d = StRun;
    end else if (is_md) begin
      md_start    = 1'b1;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_write  = 1'b0;
      exmem_flush = 1'b1;
      cnt_d       = is_div ? DivCntInit : MulCntInit;
      state_d     = StMdWait;
    end else if (load_use) begin
      // A concurrent taken branch is re-evaluated after the bubble.
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      ifid_flush = 1'b1;
    end

    stall_count_d = stall_count_q;
    if (!reset && !pc_write) begin
      stall_count_d = stall_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      cnt_q         <= 6'd0;
      stall_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign md_busy     = (state_q == StMdWait);
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl with hand-computed expectations.
module tb_hazard_stall_ctrl;

  localparam logic [31:0] Nop    = 32'h0000_0000;
  localparam logic [31:0] LwR8   = 32'h8C28_0000;  // lw  $8,0($1)
  localparam logic [31:0] LwR0   = 32'h8C20_0000;  // lw  $0,0($1)
  localparam logic [31:0] LbR8   = 32'h8028_0000;  // lb  $8,0($1)
  localparam logic [31:0] AddR8  = 32'h0102_4820;  // add $9,$8,$2
  localparam logic [31:0] AddR0  = 32'h0002_4820;  // add $9,$0,$2
  localparam logic [31:0] SwR8   = 32'hAC28_0000;  // sw  $8,0($1)
  localparam logic [31:0] JmpR8  = 32'h0900_0000;  // j with rs bits == 8
  localparam logic [31:0] Mult34 = 32'h0064_0018;  // mult $3,$4
  localparam logic [31:0] Div34  = 32'h0064_001A;  // div  $3,$4

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ifid_instr, idex_instr;
  logic        branch_taken, exception;
  logic        pc_write, ifid_write, idex_write;
  logic        ifid_flush, idex_flush, exmem_flush;
  logic        md_start, md_abort, md_busy;
  logic [31:0] stall_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(33)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ifid_instr  (ifid_instr),
    .idex_instr  (idex_instr),
    .branch_taken(branch_taken),
    .exception   (exception),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_write  (idex_write),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .exmem_flush (exmem_flush),
    .md_start    (md_start),
    .md_abort    (md_abort),
    .md_busy     (md_busy),
    .stall_count (stall_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled mid-low-phase.
  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  int starts;

  initial begin
    reset        = 1'b1;
    ifid_instr   = Nop;
    idex_instr   = Mult34;
    branch_taken = 1'b0;
    exception    = 1'b0;
    next_cycle();
    next_cycle();
    // Reset overrides the mul/div decode in ID/EX
    check_eq("rst_pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("rst_md_start", {31'd0, md_start}, 32'd0);
    check_eq("rst_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd0);
    check_eq("rst_md_busy", {31'd0, md_busy}, 32'd0);
    check_eq("rst_stall_count", stall_count, 32'd0);

    reset      = 1'b0;
    idex_instr = Nop;
    next_cycle();

    // Load-use bubble on rs
    idex_instr = LwR8;
    ifid_instr = AddR8;
    #1;
    check_eq("lu_pc_write", {31'd0, pc_write}, 32'd0);
    check_eq("lu_ifid_write", {31'd0, ifid_write}, 32'd0);
    check_eq("lu_idex_write", {31'd0, idex_write}, 32'd1);
    check_eq("lu_idex_flush", {31'd0, idex_flush}, 32'd1);
    next_cycle();
    idex_instr = Nop;
    #1;
    check_eq("lu_after_pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("lu_stall_count", stall_count, 32'd1);

    // Destination $0 never stalls
    idex_instr = LwR0;
    ifid_instr = AddR0;
    #1;
    check_eq("lu_r0_pc_write", {31'd0, pc_write}, 32'd1);
    // Store reads rt -> stall
    idex_instr = LwR8;
    ifid_instr = SwR8;
    #1;
    check_eq("lu_sw_idex_flush", {31'd0, idex_flush}, 32'd1);
    next_cycle();  // stall_count -> 2
    // Jump does not read rs
    ifid_instr = JmpR8;
    #1;
    check_eq("lu_j_pc_write", {31'd0, pc_write}, 32'd1);
    // lb also counts as a load
    idex_instr = LbR8;
    ifid_instr = AddR8;
    #1;
    check_eq("lu_lb_pc_write", {31'd0, pc_write}, 32'd0);
    idex_instr = Nop;
    ifid_instr = Nop;
    #1;
    next_cycle();
    check_eq("pre_mult_stall_count", stall_count, 32'd2);

    // Multiply: 4 hold cycles, release on the fifth
    idex_instr = Mult34;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("mul_pc_write", {31'd0, pc_write}, 32'd0);
      check_eq("mul_exmem_flush", {31'd0, exmem_flush}, 32'd1);
      check_eq("mul_md_start", {31'd0, md_start}, (i == 0) ? 32'd1 : 32'd0);
      check_eq("mul_md_busy", {31'd0, md_busy}, (i == 0) ? 32'd0 : 32'd1);
      next_cycle();
    end
    check_eq("mul_rel_pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("mul_rel_md_start", {31'd0, md_start}, 32'd0);
    check_eq("mul_rel_exmem_flush", {31'd0, exmem_flush}, 32'd0);
    next_cycle();
    idex_instr = Nop;
    #1;
    check_eq("mul_done_md_busy", {31'd0, md_busy}, 32'd0);
    check_eq("mul_stall_count", stall_count, 32'd6);

    // Divide: 33 hold cycles, a single start pulse
    idex_instr = Div34;
    starts     = 0;
    #1;
    for (int i = 0; i < 33; i++) begin
      check_eq("div_pc_write", {31'd0, pc_write}, 32'd0);
      if (md_start) starts++;
      next_cycle();
    end
    if (md_start) starts++;
    check_eq("div_rel_pc_write", {31'd0, pc_write}, 32'd1);
    check_eq("div_rel_md_busy", {31'd0, md_busy}, 32'd1);
    check_eq("div_start_pulses", starts, 32'd1);
    next_cycle();
    idex_instr = Nop;
    #1;
    check_eq("div_stall_count", stall_count, 32'd39);

    // Exception on the second multiply hold cycle
    idex_instr = Mult34;
    #1;
    next_cycle();
    exception = 1'b1;
    #1;
    check_eq("exc_flushes", {29'd0, ifid_flush, idex_flush, exmem_flush}, 32'd7);
    check_eq("exc_md_abort", {31'd0, md_abort}, 32'd1);
    check_eq("exc_pc_write", {31'd0, pc_write}, 32'd1);
    next_cycle();
    exception  = 1'b0;
    idex_instr = Nop;
    #1;
    check_eq("exc_after_md_busy", {31'd0, md_busy}, 32'd0);
    check_eq("exc_after_md_abort", {31'd0, md_abort}, 32'd0);
    check_eq("exc_stall_count", stall_count, 32'd40);

    // Branch together with load-use: only the stall applies
    idex_instr   = LwR8;
    ifid_instr   = AddR8;
    branch_taken = 1'b1;
    #1;
    check_eq("br_lu_ifid_flush", {31'd0, ifid_flush}, 32'd0);
    check_eq("br_lu_pc_write", {31'd0, pc_write}, 32'd0);
    next_cycle();
    idex_instr = Nop;
    #1;
    check_eq("br_ifid_flush", {31'd0, ifid_flush}, 32'd1);
    check_eq("br_pc_write", {31'd0, pc_write}, 32'd1);
    next_cycle();
    branch_taken = 1'b0;
    ifid_instr   = Nop;
    #1;
    check_eq("br_stall_count", stall_count, 32'd41);

    // Reset in the middle of a multiply wait
    idex_instr = Mult34;
    #1;
    next_cycle();
    reset = 1'b1;
    #1;
    check_eq("rst_mid_md_abort", {31'd0, md_abort}, 32'd0);
    check_eq("rst_mid_pc_write", {31'd0, pc_write}, 32'd1);
    next_cycle();
    reset      = 1'b0;
    idex_instr = Nop;
    #1;
    check_eq("rst_mid_md_busy", {31'd0, md_busy}, 32'd0);
    check_eq("rst_mid_stall_count", stall_count, 32'd0);
    check_eq("rst_mid_pc_write_after", {31'd0, pc_write}, 32'd1);

    // Wrap: preload the counter across a non-stall edge, then stall once
    force dut.stall_count_q = 32'hFFFF_FFFF;
    next_cycle();
    release dut.stall_count_q;
    #1;
    check_eq("wrap_preload", stall_count, 32'hFFFF_FFFF);
    idex_instr = LwR8;
    ifid_instr = AddR8;
    #1;
    next_cycle();
    idex_instr = Nop;
    ifid_instr = Nop;
    #1;
    check_eq("wrap_stall_count", stall_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding unit.
- Covers every hazard forwarding cannot hide:
  - load-use bubbles;
  - multi-cycle MULT/DIV occupancy of EX;
  - taken-branch and exception flushes.
- Drives the pipeline-register write enables and flushes, starts and aborts the mul/div unit, and keeps a stall-cycle counter.

Parameters:
MUL_LAT, 4, mul/div unit latency in cycles for mult/multu; legal range 1..64
DIV_LAT, 33, latency for div/divu; legal range 1..64

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ifid_instr  input  32  instruction word held in IF/ID
idex_instr  input  32  instruction word held in ID/EX
branch_taken  input  1  branch/jump in ID resolved taken this cycle
exception  input  1  exception detected in MEM this cycle
pc_write  output  1  PC update enable
ifid_write  output  1  IF/ID load enable
idex_write  output  1  ID/EX load enable
ifid_flush  output  1  load NOP into IF/ID
idex_flush  output  1  load NOP into ID/EX (bubble)
exmem_flush  output  1  load NOP into EX/MEM
md_start  output  1  one-cycle start pulse to mul/div unit
md_abort  output  1  one-cycle abort pulse to mul/div unit
md_busy  output  1  high while state is MD_WAIT
stall_count  output  32  cycles with pc_write==0 since reset; wraps

Behaviour:
- All outputs are combinational from state, counter and inputs. Registered state is limited to `state` (RUN, MD_WAIT), `cnt[5:0]` and `stall_count`.

Reset (synchronous, applied at the clock edge with reset high):
- state=RUN, cnt=0, stall_count=0.
- While reset is high: pc_write=ifid_write=idex_write=1, all flushes=0, md_start=md_abort=0.

Decode:
- is_load(idex) = op in {100011, 100000, 100100} or (op=010000 and rs=00000).
- dest = idex rt.
- uses_rs(ifid) = op not in {000010, 000011, 010000}.
- uses_rt(ifid) = op=000000, or op in {101011, 101000, 000100, 000101}, or (op=010000 and rs=00100).
- load_use = is_load and dest!=0 and ((uses_rs and ifid rs==dest) or (uses_rt and ifid rt==dest)).
- is_md(idex) = op=000000 and funct in {011000, 011001, 011010, 011011}.
- is_div = funct[1].

Priority, evaluated each cycle (first matching rule wins):
1. exception:
   - ifid_flush=idex_flush=exmem_flush=1; all write enables=1.
   - If state=MD_WAIT: md_abort=1.
   - Next state RUN, cnt=0.
   - The exception PC redirect is outside this block.
2. state=MD_WAIT and cnt!=0:
   - pc_write=ifid_write=idex_write=0, exmem_flush=1.
   - cnt decrements; branch_taken is ignored.
3. state=MD_WAIT and cnt==0:
   - Release: all writes=1, no flushes. The mul/div instruction leaves EX at this edge.
   - Next state RUN.
4. state=RUN and is_md:
   - md_start=1; hold as in rule 2.
   - cnt loads (is_div ? DIV_LAT : MUL_LAT) - 1; next state MD_WAIT.
   - Total hold = LAT cycles; EX occupancy = LAT+1 cycles.
5. state=RUN and load_use:
   - pc_write=ifid_write=0, idex_flush=1 for exactly one cycle.
   - branch_taken is ignored (the branch re-evaluates next cycle).
6. branch_taken: ifid_flush=1, all writes=1.
7. Otherwise: all writes=1, no flushes.

Other rules:
- md_busy = (state==MD_WAIT).
- md_start never fires in MD_WAIT, so no re-start on the release cycle.
- stall_count increments on every non-reset cycle with pc_write==0, wrapping 0xFFFFFFFF->0.
- Simultaneous events:
  - exception beats everything.
  - A load-use against an instruction that follows mul/div is evaluated only after release.
- Reset mid-MD_WAIT: returns to RUN with no md_abort (the mul/div unit is reset separately).

Test Plan:
1. Load-use bubble: idex=lw $8,0($1) (0x8C280000), ifid=add $9,$8,$2 -> one cycle with pc_write=0, ifid_write=0, idex_flush=1; stall_count=1. Same pattern with rt=$0 -> no stall.
2. Multiply hold: MUL_LAT=4, idex=mult $3,$4 at cycle T ->
   - T: md_start=1.
   - T..T+3: pc_write=0, exmem_flush=1, md_busy=1 from T+1.
   - T+4: release, md_busy drops.
   - stall_count=4.
3. Divide hold: DIV_LAT=33, idex=div -> 33 hold cycles, single md_start pulse, release on cycle 34.
4. Exception during MD_WAIT at hold cycle 2 -> that cycle ifid_flush=idex_flush=exmem_flush=1 and md_abort=1; next cycle state=RUN, md_busy=0.
5. Branch vs load-use: branch_taken=1 together with load_use -> only the stall is applied (ifid_flush=0); next cycle with branch_taken=1 and no hazard -> ifid_flush=1.
6. Reset asserted mid-MD_WAIT -> next cycle md_busy=0, stall_count=0, pc_write=1; stall_count wraps from 0xFFFFFFFF to 0 (forced preload).
